// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and DMType codes for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

  // DMType codes, matching the core's ctrl_encode definitions
  localparam logic [2:0] DM_WORD              = 3'd0;
  localparam logic [2:0] DM_HALFWORD          = 3'd1;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;
  localparam logic [2:0] DM_BYTE              = 3'd3;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'd4;

  // Instruction fetches are always full-word reads
  localparam logic [2:0] FETCH_TYPE = DM_WORD;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating fetch-starvation counter and IDLE grant decision
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_req,
  input  logic if_flush,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Data wins unless fetch has already lost STARVE_MAX arbitrations in a row
  always_comb begin
    grant_dm = idle & dm_req & (~if_req | (starve_cnt < CNT_MAX));
    grant_if = idle & ~grant_dm & if_req & ~if_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between instruction fetch and data ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [2:0]    dm_type,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_type,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    state, state_next;
  logic          drop, drop_next;
  logic [TW-1:0] wait_cnt;
  logic          idle, owner_if, owner_dm, busy, timeout, done;
  logic          grant_if, grant_dm;

  assign idle = (state == ST_IDLE);

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .idle     (idle),
    .if_req   (if_req),
    .if_flush (if_flush),
    .dm_req   (dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  always_comb begin
    owner_if   = (state == ST_BUSY_IF);
    owner_dm   = (state == ST_BUSY_DM);
    busy       = owner_if | owner_dm;
    timeout    = (TIMEOUT != 0) && busy && !mem_ack && (wait_cnt == T_LAST);
    done       = busy & (mem_ack | timeout);
    state_next = state;
    drop_next  = drop;

    if (grant_dm)      state_next = ST_BUSY_DM;
    else if (grant_if) state_next = ST_BUSY_IF;
    else if (done)     state_next = ST_IDLE;

    // A flushed fetch still completes on the bus; only its ack is swallowed
    if (owner_if && done)          drop_next = 1'b0;
    else if (owner_if && if_flush) drop_next = 1'b1;

    if_ack   = ~reset & owner_if & done & ~drop & ~if_flush;
    dm_ack   = ~reset & owner_dm & done;
    if_rdata = (if_ack & mem_ack) ? mem_rdata : '0;
    dm_rdata = (dm_ack & mem_ack) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (timeout) bus_err <= 1'b1;

      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_type  <= dm_type;
        wait_cnt  <= '0;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_type  <= FETCH_TYPE;
        wait_cnt  <= '0;
      end else if (done) begin
        mem_req <= 1'b0;
      end else if (busy) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
    end
  end

endmodule
